// File: rtl/clock_pkg.sv
// Shared constants and width helper for the time-of-day counter.
package clock_pkg;

    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 60;
    localparam int HR_MOD_DEF  = 24;

    // Bits needed to hold 0..modulus-1; never less than one bit.
    function automatic int field_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/timekeeper_core_if.sv
// Control, alarm-setting and time-display signals between the clock core and its host.
interface timekeeper_core_if #(
    parameter int SW = 6,
    parameter int MW = 6,
    parameter int HW = 5
);
    logic          setup;
    logic          min_adv;
    logic          hr_adv;
    logic          alarm_en;
    logic [MW-1:0] alarm_min;
    logic [HW-1:0] alarm_hr;
    logic          alarm_ack;
    logic [SW-1:0] seconds;
    logic [MW-1:0] minutes;
    logic [HW-1:0] hours;
    logic          tick;
    logic          alarm;

    modport master (
        output setup, min_adv, hr_adv, alarm_en, alarm_min, alarm_hr, alarm_ack,
        input  seconds, minutes, hours, tick, alarm
    );

    modport slave (
        input  setup, min_adv, hr_adv, alarm_en, alarm_min, alarm_hr, alarm_ack,
        output seconds, minutes, hours, tick, alarm
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear, load-to-zero and increment; wraps by explicit compare.
module mod_counter
    import clock_pkg::*;
#(
    parameter int MOD = SEC_MOD_DEF,
    parameter int W   = field_w(MOD)
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_zero_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_zero_i)
            value_d = '0;
        else if (inc_i)
            value_d = (value_q == LAST) ? '0 : value_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value_o = value_q;
    assign carry_o = inc_i & (value_q == LAST);
endmodule

// File: rtl/timekeeper_core.sv
// Time-of-day counter: prescaler tick, seconds/minutes/hours chain, set mode and latched alarm.
module timekeeper_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEC_MOD  = SEC_MOD_DEF,
    parameter int MIN_MOD  = MIN_MOD_DEF,
    parameter int HR_MOD   = HR_MOD_DEF
) (
    input  logic               clk_i,
    input  logic               clr_i,
    timekeeper_core_if.slave   tk
);
    localparam int SW = field_w(SEC_MOD);
    localparam int MW = field_w(MIN_MOD);
    localparam int HW = field_w(HR_MOD);
    localparam int PW = field_w(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q;
    logic          alarm_q, alarm_d;
    logic          min_adv_q, hr_adv_q;

    logic [SW-1:0] sec_val;
    logic [MW-1:0] min_val;
    logic [HW-1:0] hr_val;
    logic          sec_c, min_c, hr_c;
    logic          sec_wrap, min_rise, hr_rise;
    logic          min_inc, hr_inc;
    logic          alarm_hit;
    int            nxt_min, nxt_hr;

    assign sec_wrap = ~tk.setup & (presc_q == PRESC_LAST);
    assign min_rise = tk.min_adv & ~min_adv_q;
    assign hr_rise  = tk.hr_adv & ~hr_adv_q;

    // In set mode the seconds counter never increments, so no carry leaks upward.
    assign min_inc = tk.setup ? min_rise : sec_c;
    assign hr_inc  = tk.setup ? hr_rise  : min_c;

    assign presc_d = (tk.setup || sec_wrap) ? '0 : presc_q + PW'(1);

    mod_counter #(.MOD(SEC_MOD), .W(SW)) u_sec (
        .clk_i(clk_i), .clr_i(clr_i), .load_zero_i(tk.setup), .inc_i(sec_wrap),
        .value_o(sec_val), .carry_o(sec_c)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MW)) u_min (
        .clk_i(clk_i), .clr_i(clr_i), .load_zero_i(1'b0), .inc_i(min_inc),
        .value_o(min_val), .carry_o(min_c)
    );

    mod_counter #(.MOD(HR_MOD), .W(HW)) u_hr (
        .clk_i(clk_i), .clr_i(clr_i), .load_zero_i(1'b0), .inc_i(hr_inc),
        .value_o(hr_val), .carry_o(hr_c)
    );

    // Compare against the time this edge will produce, so ALARM rises together with it.
    always_comb begin
        nxt_min   = min_c ? 0 : int'(min_val) + 1;
        nxt_hr    = !min_c ? int'(hr_val) : (hr_c ? 0 : int'(hr_val) + 1);
        alarm_hit = sec_wrap && sec_c && tk.alarm_en
                    && (nxt_min == int'(tk.alarm_min))
                    && (nxt_hr == int'(tk.alarm_hr));
        alarm_d   = alarm_q;
        if (alarm_hit)
            alarm_d = 1'b1;
        else if (tk.alarm_ack || !tk.alarm_en)
            alarm_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            alarm_q   <= 1'b0;
            min_adv_q <= 1'b0;
            hr_adv_q  <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= sec_wrap;
            alarm_q   <= alarm_d;
            min_adv_q <= tk.min_adv;
            hr_adv_q  <= tk.hr_adv;
        end
    end

    assign tk.seconds = sec_val;
    assign tk.minutes = min_val;
    assign tk.hours   = hr_val;
    assign tk.tick    = tick_q;
    assign tk.alarm   = alarm_q;
endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench: 60/60/24 core with TICK_DIV=4, plus a 10/3/12 core with TICK_DIV=2.
module tb_timekeeper_core;
    import clock_pkg::*;

    logic clk;
    logic clr_a, clr_b;
    int   n_vec = 0;
    int   n_err = 0;

    timekeeper_core_if #(.SW(field_w(60)), .MW(field_w(60)), .HW(field_w(24))) bus_a ();
    timekeeper_core_if #(.SW(field_w(10)), .MW(field_w(3)),  .HW(field_w(12))) bus_b ();

    timekeeper_core #(.TICK_DIV(4)) dut_a (
        .clk_i(clk), .clr_i(clr_a), .tk(bus_a)
    );

    timekeeper_core #(.TICK_DIV(2), .SEC_MOD(10), .MIN_MOD(3), .HR_MOD(12)) dut_b (
        .clk_i(clk), .clr_i(clr_b), .tk(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_time_a(input string tag, input int h, input int m, input int s);
        check_val({tag, ".hr"},  int'(bus_a.hours),   h);
        check_val({tag, ".min"}, int'(bus_a.minutes), m);
        check_val({tag, ".sec"}, int'(bus_a.seconds), s);
    endtask

    task automatic check_time_b(input string tag, input int h, input int m, input int s);
        check_val({tag, ".hr"},  int'(bus_b.hours),   h);
        check_val({tag, ".min"}, int'(bus_b.minutes), m);
        check_val({tag, ".sec"}, int'(bus_b.seconds), s);
    endtask

    task automatic adv_a(input logic m, input logic h);
        bus_a.min_adv = m;
        bus_a.hr_adv  = h;
        step(1);
        bus_a.min_adv = 1'b0;
        bus_a.hr_adv  = 1'b0;
        step(1);
    endtask

    // Clear, then use set mode to reach hh:mm:00 (setup stays asserted).
    task automatic preset_a(input int h, input int m);
        bus_a.setup = 1'b1;
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        for (int i = 0; i < h; i++) adv_a(1'b1, 1'b1);
        for (int i = h; i < m; i++) adv_a(1'b1, 1'b0);
    endtask

    int max_s, max_m, max_h;
    bit b_alarm_seen;

    initial begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        bus_a.setup = 1'b0; bus_a.min_adv = 1'b0; bus_a.hr_adv = 1'b0;
        bus_a.alarm_en = 1'b0; bus_a.alarm_min = '0; bus_a.alarm_hr = '0; bus_a.alarm_ack = 1'b0;
        bus_b.setup = 1'b0; bus_b.min_adv = 1'b0; bus_b.hr_adv = 1'b0;
        bus_b.alarm_en = 1'b1; bus_b.alarm_min = 2'd0; bus_b.alarm_hr = 4'd12; bus_b.alarm_ack = 1'b0;

        // Reset state and basic prescaler timing
        step(2);
        check_time_a("rst", 0, 0, 0);
        check_val("rst.tick",  int'(bus_a.tick),  0);
        check_val("rst.alarm", int'(bus_a.alarm), 0);
        clr_a = 1'b0;
        step(3);
        check_val("c3.sec",  int'(bus_a.seconds), 0);
        check_val("c3.tick", int'(bus_a.tick), 0);
        step(1);
        check_val("c4.sec",  int'(bus_a.seconds), 1);
        check_val("c4.tick", int'(bus_a.tick), 1);
        step(1);
        check_val("c5.tick", int'(bus_a.tick), 0);
        step(3);
        check_val("c8.sec",  int'(bus_a.seconds), 2);
        check_val("c8.tick", int'(bus_a.tick), 1);

        // CLR mid-count
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        step(6);
        check_val("c6.sec", int'(bus_a.seconds), 1);
        clr_a = 1'b1;
        step(1);
        check_time_a("clr7", 0, 0, 0);
        check_val("clr7.tick", int'(bus_a.tick), 0);

        // 23:59:59 rollover
        preset_a(23, 59);
        check_time_a("set2359", 23, 59, 0);
        bus_a.setup = 1'b0;
        step(236);
        check_time_a("t235959", 23, 59, 59);
        check_val("t235959.tick", int'(bus_a.tick), 1);
        step(3);
        check_time_a("hold235959", 23, 59, 59);
        check_val("hold.tick", int'(bus_a.tick), 0);
        step(1);
        check_time_a("wrap000000", 0, 0, 0);
        check_val("wrap.tick", int'(bus_a.tick), 1);
        step(1);
        check_val("wrap1.tick", int'(bus_a.tick), 0);
        check_time_a("wrap1", 0, 0, 0);

        // Set mode: held MIN_ADV advances once, no carry into hours
        preset_a(5, 59);
        check_time_a("set0559", 5, 59, 0);
        bus_a.min_adv = 1'b1;
        step(1);
        check_time_a("hold1", 5, 0, 0);
        step(9);
        check_time_a("hold10", 5, 0, 0);
        check_val("hold10.tick", int'(bus_a.tick), 0);
        bus_a.min_adv = 1'b0;
        step(1);
        bus_a.min_adv = 1'b1;
        bus_a.hr_adv  = 1'b1;
        step(1);
        check_time_a("both", 6, 1, 0);
        bus_a.min_adv = 1'b0;
        bus_a.hr_adv  = 1'b0;
        step(1);

        // Alarm at 07:30; set-mode arrival must not fire
        bus_a.alarm_en  = 1'b1;
        bus_a.alarm_min = 6'd30;
        bus_a.alarm_hr  = 5'd7;
        preset_a(7, 30);
        check_time_a("set0730", 7, 30, 0);
        check_val("set0730.alarm", int'(bus_a.alarm), 0);
        preset_a(7, 29);
        bus_a.setup = 1'b0;
        step(236);
        check_time_a("t072959", 7, 29, 59);
        check_val("t072959.alarm", int'(bus_a.alarm), 0);
        step(4);
        check_time_a("t073000", 7, 30, 0);
        check_val("t073000.alarm", int'(bus_a.alarm), 1);
        check_val("t073000.tick",  int'(bus_a.tick), 1);
        step(5);
        check_val("alarm.held", int'(bus_a.alarm), 1);
        bus_a.alarm_ack = 1'b1;
        step(1);
        check_val("alarm.ack", int'(bus_a.alarm), 0);
        bus_a.alarm_ack = 1'b0;

        // Ack held across the matching advance: set wins for one cycle
        preset_a(7, 29);
        bus_a.setup = 1'b0;
        step(236);
        bus_a.alarm_ack = 1'b1;
        step(4);
        check_val("setwins.alarm", int'(bus_a.alarm), 1);
        step(1);
        check_val("setwins.after", int'(bus_a.alarm), 0);
        bus_a.alarm_ack = 1'b0;
        step(4);
        check_time_a("t073001", 7, 30, 1);
        check_val("t073001.alarm", int'(bus_a.alarm), 0);

        // Small non-power-of-two moduli, full 360 s wrap
        clr_a = 1'b1;
        clr_b = 1'b0;
        max_s = 0; max_m = 0; max_h = 0;
        b_alarm_seen = 1'b0;
        for (int cyc = 1; cyc <= 720; cyc++) begin
            step(1);
            if (int'(bus_b.seconds) > max_s) max_s = int'(bus_b.seconds);
            if (int'(bus_b.minutes) > max_m) max_m = int'(bus_b.minutes);
            if (int'(bus_b.hours)   > max_h) max_h = int'(bus_b.hours);
            if (bus_b.alarm) b_alarm_seen = 1'b1;
            if (cyc == 18)  check_time_b("b9s",   0, 0, 9);
            if (cyc == 20)  check_time_b("b10s",  0, 1, 0);
            if (cyc == 58)  check_time_b("b29s",  0, 2, 9);
            if (cyc == 60)  check_time_b("b30s",  1, 0, 0);
            if (cyc == 718) check_time_b("b359s", 11, 2, 9);
            if (cyc == 720) check_time_b("b360s", 0, 0, 0);
        end
        check_val("b.max_sec", max_s, 9);
        check_val("b.max_min", max_m, 2);
        check_val("b.max_hr",  max_h, 11);
        check_val("b.alarm_hr12", int'(b_alarm_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
